// File: rtl/serial_cmp_ctrl.sv
// Serial MSB-first magnitude-compare sequencer: walks two WIDTH-bit operands one
// bit pair per clock through an external 1-bit comparator and latches the verdict.
module serial_cmp_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             bit_a,
    output logic             bit_b,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             err,
    output logic [IDXW-1:0]  bit_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b;
    logic [IDXW-1:0]  r_idx, w_idx_nxt;
    logic             r_gt, r_eq, r_lt, r_err;
    logic             w_gt_nxt, w_eq_nxt, w_lt_nxt, w_err_nxt;
    logic             w_load;
    logic [2:0]       w_flags;
    logic             w_onehot;

    assign w_flags  = {cmp_gt, cmp_eq, cmp_lt};
    assign w_onehot = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gt_nxt    = r_gt;
        w_eq_nxt    = r_eq;
        w_lt_nxt    = r_lt;
        w_err_nxt   = r_err;
        w_load      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = IDXW'(WIDTH - 1);
                    w_gt_nxt    = 1'b0;
                    w_eq_nxt    = 1'b0;
                    w_lt_nxt    = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A broken comparator outranks any verdict it happens to produce.
                if (!w_onehot) begin
                    w_err_nxt   = 1'b1;
                    w_gt_nxt    = 1'b0;
                    w_eq_nxt    = 1'b0;
                    w_lt_nxt    = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (cmp_gt) begin
                    w_gt_nxt    = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (cmp_lt) begin
                    w_lt_nxt    = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_idx == '0) begin
                    w_eq_nxt    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx - IDXW'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_gt    <= w_gt_nxt;
            r_eq    <= w_eq_nxt;
            r_lt    <= w_lt_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_a <= a_in;
                r_b <= b_in;
            end
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign bit_a   = busy ? r_a[r_idx] : 1'b0;
    assign bit_b   = busy ? r_b[r_idx] : 1'b0;
    assign gt      = r_gt;
    assign eq      = r_eq;
    assign lt      = r_lt;
    assign err     = r_err;
    assign bit_idx = r_idx;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl (WIDTH=8) with a behavioural 1-bit comparator
// whose flags can be corrupted on one chosen bit to exercise the error path.
module tb_serial_cmp_ctrl;

    localparam int WIDTH = 8;
    localparam int IDXW  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in, b_in;
    logic             bit_a, bit_b;
    logic             cmp_gt, cmp_eq, cmp_lt;
    logic             busy, done, gt, eq, lt, err;
    logic [IDXW-1:0]  bit_idx;
    logic             inject;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Reference comparator; when inject is set, bit 5 reports both gt and lt.
    logic w_bad;
    assign w_bad  = inject && busy && (bit_idx == 3'd5);
    assign cmp_gt = w_bad ? 1'b1 : (bit_a & ~bit_b);
    assign cmp_lt = w_bad ? 1'b1 : (~bit_a & bit_b);
    assign cmp_eq = w_bad ? 1'b0 : ~(bit_a ^ bit_b);

    serial_cmp_ctrl #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .bit_a   (bit_a),
        .bit_b   (bit_b),
        .cmp_gt  (cmp_gt),
        .cmp_eq  (cmp_eq),
        .cmp_lt  (cmp_lt),
        .busy    (busy),
        .done    (done),
        .gt      (gt),
        .eq      (eq),
        .lt      (lt),
        .err     (err),
        .bit_idx (bit_idx)
    );

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] a_mid;   // value driven on a_in once the operation is running
        logic [3:0] exp_res; // {gt, eq, lt, err}
        int         exp_n;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns n such that done is observed in the cycle after edge k+n.
    task automatic wait_done(input string name, output int n);
        logic got;
        got = 1'b0;
        n   = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                n   = c;
                got = 1'b1;
                break;
            end
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        start_op(v.a, v.b);
        a_in = v.a_mid;
        check({v.name, " busy"}, 32'(busy), 32'd1);
        wait_done(v.name, n);
        check({v.name, " latency"}, 32'(n), 32'(v.exp_n));
        check({v.name, " result"}, 32'({gt, eq, lt, err}), 32'(v.exp_res));
        check({v.name, " bit_idx"}, 32'(bit_idx), 32'(v.exp_idx));
        check({v.name, " busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({v.name, " done_pulse"}, 32'(done), 32'd0);
        check({v.name, " result_held"}, 32'({gt, eq, lt, err}), 32'(v.exp_res));
    endtask

    initial begin
        int n;
        logic seen;

        vecs[0] = '{"msb_gt",   8'h80, 8'h7F, 8'h80, 4'b1000, 1, 3'd7};
        vecs[1] = '{"mid_lt",   8'h12, 8'h14, 8'h12, 4'b0010, 6, 3'd2};
        vecs[2] = '{"eq_a5",    8'hA5, 8'hA5, 8'hFF, 4'b0100, 8, 3'd0};
        vecs[3] = '{"lsb_lt",   8'h00, 8'h01, 8'h00, 4'b0010, 8, 3'd0};
        vecs[4] = '{"lsb_gt",   8'hFF, 8'hFE, 8'hFF, 4'b1000, 8, 3'd0};
        vecs[5] = '{"msb_lt",   8'h40, 8'h80, 8'h40, 4'b0010, 1, 3'd7};
        vecs[6] = '{"mid_gt",   8'h0F, 8'h0B, 8'h0F, 4'b1000, 6, 3'd2};
        vecs[7] = '{"eq_zero",  8'h00, 8'h00, 8'h00, 4'b0100, 8, 3'd0};

        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        inject = 1'b0;
        #12;
        check("reset outputs", 32'({busy, done, gt, eq, lt, err, bit_a, bit_b}), 32'd0);
        check("reset bit_idx", 32'(bit_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Async reset while a result is held clears it without waiting for a clock.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("idle reset result", 32'({gt, eq, lt, err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a run aborts it with no done pulse.
        start_op(8'h00, 8'h00);
        repeat (2) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("midrun reset outputs", 32'({busy, done, gt, eq, lt, err}), 32'd0);
        check("midrun reset bit_idx", 32'(bit_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= done;
        end
        check("no done after reset", 32'(seen), 32'd0);
        check("busy after reset", 32'(busy), 32'd0);

        // start pulses during RUN and DONE are ignored.
        start_op(8'h12, 8'h14);
        @(negedge clk);
        a_in  = 8'hFF;
        b_in  = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("hs_run", n);
        check("hs_run latency", 32'(n + 2), 32'd6);
        check("hs_run result", 32'({gt, eq, lt, err}), 32'b0010);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hs_done ignored idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("hs_done ignored", 32'(busy), 32'd0);
        check("hs_done result held", 32'({gt, eq, lt, err}), 32'b0010);

        // start held through DONE is taken on the first IDLE edge; prior result held until then.
        start_op(8'h80, 8'h7F);
        wait_done("hold_first", n);
        check("hold_first latency", 32'(n), 32'd1);
        a_in  = 8'h40;
        b_in  = 8'h80;
        start = 1'b1;
        @(negedge clk);
        check("hold idle busy", 32'(busy), 32'd0);
        check("hold idle result", 32'({gt, eq, lt, err}), 32'b1000);
        @(negedge clk);
        start = 1'b0;
        check("hold accepted busy", 32'(busy), 32'd1);
        check("hold accepted cleared", 32'({gt, eq, lt, err}), 32'd0);
        wait_done("hold_second", n);
        check("hold_second latency", 32'(n), 32'd1);
        check("hold_second result", 32'({gt, eq, lt, err}), 32'b0010);

        // Corrupted comparator flags on the third examined bit.
        inject = 1'b1;
        start_op(8'h00, 8'h00);
        wait_done("fault", n);
        check("fault latency", 32'(n), 32'd3);
        check("fault result", 32'({gt, eq, lt, err}), 32'b0001);
        check("fault bit_idx", 32'(bit_idx), 32'd5);
        inject = 1'b0;
        @(negedge clk);
        check("fault held", 32'({gt, eq, lt, err}), 32'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
- Sequencer for the team's 1-bit magnitude comparator (`compare`: inputs a, b; outputs out1 A>B, out2 A==B, out3 A<B).
- Compares two WIDTH-bit unsigned operands serially, MSB first, by presenting one bit pair per clock to an external `compare` instance.
- Samples the instance's three flags each cycle and terminates early on the first unequal bit.
- Start/busy/done handshake to the requester; latched one-hot result plus a protocol-error flag.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- IDXW, $clog2(WIDTH), width of the bit-index counter and of bit_idx.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request pulse; accepted only in IDLE.
- a_in  in  WIDTH  operand A, sampled on the accepting edge.
- b_in  in  WIDTH  operand B, sampled on the accepting edge.
- bit_a  out  1  current A bit; drives compare.a.
- bit_b  out  1  current B bit; drives compare.b.
- cmp_gt  in  1  from compare.out1.
- cmp_eq  in  1  from compare.out2.
- cmp_lt  in  1  from compare.out3.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- gt  out  1  A>B result, held until the next accepted start.
- eq  out  1  A==B result, held until the next accepted start.
- lt  out  1  A<B result, held until the next accepted start.
- err  out  1  comparator flags were not one-hot during the operation; held like the result.
- bit_idx  out  IDXW  index of the bit currently presented.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE.
  - busy, done, gt, eq, lt, err, bit_a, bit_b all 0; bit_idx=0.
  - Internal operand registers cleared.
- Reset mid-RUN aborts the operation immediately; no done pulse is produced; results read 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - bit_a=bit_b=0.
  - On a rising edge with start=1: latch a_in and b_in, set idx=WIDTH-1, clear gt/eq/lt/err, go to RUN.
- RUN:
  - busy=1.
  - bit_a=A_reg[idx] and bit_b=B_reg[idx], driven combinationally from registers. The comparator path is purely combinational and settles within the cycle.
  - Each rising edge samples {cmp_gt, cmp_eq, cmp_lt}, checked in this order:
    - Flags not one-hot (zero or more than one set): err=1, gt=eq=lt=0, go to DONE.
    - cmp_gt=1: gt=1, go to DONE.
    - cmp_lt=1: lt=1, go to DONE.
    - cmp_eq=1 and idx==0: eq=1, go to DONE.
    - cmp_eq=1 and idx>0: idx decrements; stay in RUN.
- DONE:
  - done=1 for exactly one cycle; busy=0; bit_a=bit_b=0.
  - Next edge returns to IDLE unconditionally.
- bit_idx reflects idx in RUN and holds its last value in DONE/IDLE.
- Latency: if start is accepted at edge k and the decisive bit is the n-th examined (n=1..WIDTH), done is high in the cycle after edge k+n.
  - Best case (MSB differs): n=1.
  - Worst case (operands equal): n=WIDTH.
- start:
  - Ignored in RUN and DONE; operands are not re-sampled.
  - A start held high through DONE is accepted on the first IDLE edge.
  - Back-to-back throughput is therefore n+2 cycles per operation.
- Operand changes on a_in/b_in after acceptance have no effect on the running comparison.
- Exactly one of gt/eq/lt/err is 1 after any completed operation; all four are 0 after reset until the first completion.

Test Plan (WIDTH=8, bench instantiates `compare` wired to bit_a/bit_b/cmp_*):
- Reset check: rst_n=0 mid-RUN with a_in=8'h00, b_in=8'h00 → busy, done, gt/eq/lt/err drop to 0 asynchronously; no done pulse after release.
- MSB early exit: a_in=8'h80, b_in=8'h7F, start → gt=1, done in the cycle after edge k+1, bit_idx=7.
- Mid-word exit: a_in=8'h12, b_in=8'h14, start → lt=1 at bit 2, n=6, done after edge k+6, bit_idx=2.
- Full-length equal: a_in=b_in=8'hA5, start → eq=1, busy high for 8 cycles, done after edge k+8; a_in changed to 8'hFF during RUN does not alter the result.
- Handshake: pulse start during RUN and during DONE → ignored. Hold start high across DONE → a new operation starts in the next IDLE cycle; results from the first operation are held until that acceptance.
- Fault injection: bench forces cmp_gt=cmp_lt=1 on the 3rd bit → err=1, gt=eq=lt=0, done after edge k+3.
